// File: rtl/ip_color_pkg.sv
// Shared defaults, coefficient address map and sync bundle for the colour matrix.
package ip_color_pkg;

  localparam int CIIW_DEF = 8;
  localparam int CIPW_DEF = 0;
  localparam int COIW_DEF = 8;
  localparam int COPW_DEF = 4;
  localparam int CFW_DEF  = 14;
  localparam int CFPW_DEF = 12;
  localparam int PIPE_DEF = 2;

  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 3;

  // Coefficient K[i][j] lives at address 3*i+j; anything above the last address is ignored.
  localparam int          K_NUM       = 9;
  localparam logic [3:0]  K_ADDR_LAST = 4'd8;

  typedef struct packed {
    logic hstr;
    logic hend;
    logic href;
    logic bypass;
  } sync_t;

  function automatic bit is_diag(input int addr);
    return (addr / 3) == (addr % 3);
  endfunction

  function automatic int identity_coef(input int cfpw, input int addr);
    return is_diag(addr) ? (1 << cfpw) : 0;
  endfunction

endpackage

// File: rtl/ip_color_dot3.sv
// One output row of the colour matrix: signed 3-term dot product, round, shift, clamp.
// Result is combinational from the last internal stage; the caller owns the output register.
module ip_color_dot3
  import ip_color_pkg::*;
#(
  parameter int CIW   = CIIW_DEF + CIPW_DEF,
  parameter int CFW   = CFW_DEF,
  parameter int COW   = COIW_DEF + COPW_DEF,
  parameter int SHIFT = CFPW_DEF + CIPW_DEF - COPW_DEF,
  parameter int PIPE  = PIPE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CIW-1:0]        in0,
  input  logic [CIW-1:0]        in1,
  input  logic [CIW-1:0]        in2,
  input  logic signed [CFW-1:0] k0,
  input  logic signed [CFW-1:0] k1,
  input  logic signed [CFW-1:0] k2,
  output logic [COW-1:0]        result
);

  localparam int PW = CIW + CFW + 1;
  localparam int SW = PW + 2;
  localparam int RW = SW + 1;

  localparam logic signed [RW-1:0] RND  = RW'(1) <<< (SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = $signed({{(RW-COW){1'b0}}, {COW{1'b1}}});

  logic signed [PW-1:0] prod_c [3];
  logic signed [PW-1:0] prod_s [3];
  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] sum_s;
  logic signed [RW-1:0] rounded;
  logic signed [RW-1:0] shifted;

  // Pixels are unsigned, so a zero MSB is prepended before the signed multiply.
  always_comb begin
    prod_c[0] = PW'($signed({1'b0, in0})) * PW'(k0);
    prod_c[1] = PW'($signed({1'b0, in1})) * PW'(k1);
    prod_c[2] = PW'($signed({1'b0, in2})) * PW'(k2);
  end

  if (PIPE >= 2) begin : g_prod_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < 3; j++) prod_s[j] <= '0;
      end else begin
        for (int j = 0; j < 3; j++) prod_s[j] <= prod_c[j];
      end
    end
  end else begin : g_prod_comb
    always_comb begin
      for (int j = 0; j < 3; j++) prod_s[j] = prod_c[j];
    end
  end

  assign sum_c = SW'(prod_s[0]) + SW'(prod_s[1]) + SW'(prod_s[2]);

  if (PIPE == 3) begin : g_sum_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_s <= '0;
      else        sum_s <= sum_c;
    end
  end else begin : g_sum_comb
    assign sum_s = sum_c;
  end

  always_comb begin
    rounded = RW'(sum_s) + RND;
    shifted = rounded >>> SHIFT;
    if (shifted[RW-1])       result = '0;
    else if (shifted > MAXV) result = '1;
    else                     result = shifted[COW-1:0];
  end

endmodule

// File: rtl/ip_color_matrix.sv
// 3x3 colour-space matrix with double-buffered coefficients, per-pixel bypass and
// sync signals delayed to match the configurable pipeline latency.
module ip_color_matrix
  import ip_color_pkg::*;
#(
  parameter int CIIW = CIIW_DEF,
  parameter int CIPW = CIPW_DEF,
  parameter int COIW = COIW_DEF,
  parameter int COPW = COPW_DEF,
  parameter int CFW  = CFW_DEF,
  parameter int CFPW = CFPW_DEF,
  parameter int PIPE = PIPE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CIIW+CIPW-1:0]   i_data_c0,
  input  logic [CIIW+CIPW-1:0]   i_data_c1,
  input  logic [CIIW+CIPW-1:0]   i_data_c2,
  input  logic                   i_hstr,
  input  logic                   i_hend,
  input  logic                   i_href,
  input  logic                   i_bypass,
  input  logic                   i_coef_wr,
  input  logic [3:0]             i_coef_addr,
  input  logic signed [CFW-1:0]  i_coef_wdata,
  output logic [COIW+COPW-1:0]   o_data_c0,
  output logic [COIW+COPW-1:0]   o_data_c1,
  output logic [COIW+COPW-1:0]   o_data_c2,
  output logic                   o_hstr,
  output logic                   o_hend,
  output logic                   o_href,
  output logic                   o_coef_pend
);

  localparam int CIW   = CIIW + CIPW;
  localparam int COW   = COIW + COPW;
  localparam int SHIFT = CFPW + CIPW - COPW;
  localparam int BSH   = COPW - CIPW;

  if (PIPE < PIPE_MIN || PIPE > PIPE_MAX) begin : g_bad_pipe
    $error("ip_color_matrix: PIPE=%0d outside %0d..%0d", PIPE, PIPE_MIN, PIPE_MAX);
  end
  if (SHIFT < 1) begin : g_bad_shift
    $error("ip_color_matrix: SHIFT=%0d must be at least 1", SHIFT);
  end

  logic signed [CFW-1:0] active_k [K_NUM];
  logic signed [CFW-1:0] shadow_k [K_NUM];
  logic signed [CFW-1:0] eff_k    [K_NUM];
  logic                  coef_wr_ok;
  logic                  coef_xfer;

  assign coef_wr_ok = i_coef_wr && (i_coef_addr <= K_ADDR_LAST);
  assign coef_xfer  = o_coef_pend && (i_hstr || !i_href);

  // The copy takes the shadow as it was before this cycle's write, so a coinciding write stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < K_NUM; a++) begin
        active_k[a] <= CFW'(identity_coef(CFPW, a));
        shadow_k[a] <= CFW'(identity_coef(CFPW, a));
      end
      o_coef_pend <= 1'b0;
    end else begin
      if (coef_xfer)  active_k <= shadow_k;
      if (coef_wr_ok) shadow_k[i_coef_addr] <= i_coef_wdata;
      o_coef_pend <= coef_wr_ok || (o_coef_pend && !coef_xfer);
    end
  end

  // The pixel in the transfer cycle already sees the new bank.
  always_comb begin
    for (int a = 0; a < K_NUM; a++) eff_k[a] = coef_xfer ? shadow_k[a] : active_k[a];
  end

  logic [2:0][CIW-1:0] din;
  logic [2:0][COW-1:0] mat_out;
  logic [2:0][COW-1:0] byp_in;
  logic [2:0][COW-1:0] byp_d;
  sync_t               sync_in;
  sync_t               sync_d;

  assign din = {i_data_c2, i_data_c1, i_data_c0};

  for (genvar i = 0; i < 3; i++) begin : g_row
    ip_color_dot3 #(
      .CIW(CIW), .CFW(CFW), .COW(COW), .SHIFT(SHIFT), .PIPE(PIPE)
    ) u_dot3 (
      .clk(clk), .rst_n(rst_n),
      .in0(din[0]), .in1(din[1]), .in2(din[2]),
      .k0(eff_k[3*i]), .k1(eff_k[3*i+1]), .k2(eff_k[3*i+2]),
      .result(mat_out[i])
    );
  end

  function automatic logic [COW-1:0] bypass_sat(input logic [CIW-1:0] v);
    logic [CIW+COW-1:0] w;
    w = {{COW{1'b0}}, v};
    if (BSH >= 0) w = w << BSH;
    else          w = w >> (-BSH);
    return (w > {{CIW{1'b0}}, {COW{1'b1}}}) ? {COW{1'b1}} : w[COW-1:0];
  endfunction

  always_comb begin
    for (int c = 0; c < 3; c++) byp_in[c] = bypass_sat(din[c]);
  end

  assign sync_in = '{hstr: i_hstr, hend: i_hend, href: i_href, bypass: i_bypass};

  // Side-band delay of PIPE-1 stages; the output register supplies the last stage.
  if (PIPE == 1) begin : g_nodly
    assign sync_d = sync_in;
    assign byp_d  = byp_in;
  end else begin : g_dly
    sync_t               sync_q [PIPE-1];
    logic [2:0][COW-1:0] byp_q  [PIPE-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < PIPE-1; s++) begin
          sync_q[s] <= '0;
          byp_q[s]  <= '0;
        end
      end else begin
        sync_q[0] <= sync_in;
        byp_q[0]  <= byp_in;
        for (int s = 1; s < PIPE-1; s++) begin
          sync_q[s] <= sync_q[s-1];
          byp_q[s]  <= byp_q[s-1];
        end
      end
    end

    assign sync_d = sync_q[PIPE-2];
    assign byp_d  = byp_q[PIPE-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hstr    <= 1'b0;
      o_hend    <= 1'b0;
      o_href    <= 1'b0;
      o_data_c0 <= '0;
      o_data_c1 <= '0;
      o_data_c2 <= '0;
    end else begin
      o_hstr    <= sync_d.hstr;
      o_hend    <= sync_d.hend;
      o_href    <= sync_d.href;
      o_data_c0 <= !sync_d.href ? '0 : (sync_d.bypass ? byp_d[0] : mat_out[0]);
      o_data_c1 <= !sync_d.href ? '0 : (sync_d.bypass ? byp_d[1] : mat_out[1]);
      o_data_c2 <= !sync_d.href ? '0 : (sync_d.bypass ? byp_d[2] : mat_out[2]);
    end
  end

endmodule
